// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared types and helpers for the parameterised serial sequence detector.
//   mode_e      : detection mode (non-overlapping / overlapping)
//   fill_width  : width needed to hold a fill count of 0..pattern_w
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } mode_e;

    // Fill count ranges 0..pattern_w inclusive, so it needs pattern_w+1 codes.
    function automatic int fill_width(input int pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// -----------------------------------------------------------------------------
// seq_detect_sat_cnt
// Saturating up-counter with a synchronous clear that wins over increment.
// Ports:
//   clk    : clock
//   areset : asynchronous active-high reset (count -> 0)
//   clr    : synchronous clear, highest priority
//   inc    : increment request, ignored once the count is all ones
//   cnt    : current count
// -----------------------------------------------------------------------------
module seq_detect_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial bit-pattern detector with run-time pattern/mode configuration and a
// saturating match counter.
// Ports:
//   clk         : clock
//   areset      : asynchronous active-high reset
//   in_valid    : qualifies in_bit
//   in_bit      : serial data, first-received bit ends up in pattern MSB
//   cfg_we      : loads cfg_pattern/cfg_overlap, clears fill count and match
//   cfg_pattern : new pattern (PATTERN_W bits)
//   cfg_overlap : new mode, 1 = overlapping, 0 = non-overlapping
//   cnt_clr     : synchronous clear of match_cnt (wins over a coincident match)
//   match       : registered one-cycle match pulse
//   match_cnt   : saturating number of matches
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                   PATTERN_W   = 3,
    parameter int                   CNT_W       = 8,
    parameter logic [PATTERN_W-1:0] RST_PATTERN = 3'b101,
    parameter logic                 RST_OVERLAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 cfg_we,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic                 cfg_overlap,
    input  logic                 cnt_clr,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int                FILL_W    = fill_width(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] hist_q,    hist_d;
    logic [FILL_W-1:0]    fill_q,    fill_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    mode_e                mode_q,    mode_d;
    logic                 match_q,   match_d;

    logic [PATTERN_W-1:0] hist_shift;
    logic [FILL_W-1:0]    fill_inc;

    // A one-bit pattern has no older history to keep; the shift degenerates
    // to just the incoming bit.
    generate
        if (PATTERN_W == 1) begin : g_shift_w1
            assign hist_shift = in_bit;
        end else begin : g_shift_wn
            assign hist_shift = {hist_q[PATTERN_W-2:0], in_bit};
        end
    endgenerate

    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        match_d   = 1'b0;
        if (cfg_we) begin
            // Reconfiguration restarts the search; a coincident bit is dropped.
            pattern_d = cfg_pattern;
            mode_d    = mode_e'(cfg_overlap);
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if ((fill_inc == FILL_FULL) && (hist_shift == pattern_q)) begin
                match_d = 1'b1;
                if (mode_q == MODE_NONOVERLAP) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RST_PATTERN;
            mode_q    <= mode_e'(RST_OVERLAP);
            match_q   <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            match_q   <= match_d;
        end
    end

    // The counter is stepped by the same detection that sets match_q, so the
    // count and the pulse update on the same edge.
    seq_detect_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (cnt_clr),
        .inc    (match_d),
        .cnt    (match_cnt)
    );

    assign match = match_q;

endmodule
